// File: rtl/seq_div_32bit.sv
// seq_div_32bit: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request pulse, accepted in IDLE or DONE only
//   dividend     numerator, sampled on the accepting edge
//   divisor      denominator, sampled on the accepting edge
//   busy         high while a division is in progress (RUN)
//   done         one-cycle pulse, results valid from this cycle
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag, set when the accepted divisor was 0
module seq_div_32bit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   div_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   quotient_q;
    logic [WIDTH-1:0]   remainder_q;
    logic               dbz_q;

    logic               rem_top;
    logic [WIDTH-1:0]   rem_sh;
    logic [WIDTH:0]     trial;
    logic               fits;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;

    // One restoring step on {R,Q}. The bit shifted out of R's top is kept in
    // rem_top: when it is set the shifted partial remainder is >= 2^WIDTH and
    // always exceeds the divisor, even though the WIDTH+1-bit trial shows a borrow.
    always_comb begin
        rem_top = rem_q[WIDTH-1];
        rem_sh  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        trial   = {1'b0, rem_sh} + {1'b1, ~div_q} + (WIDTH+1)'(1);
        fits    = rem_top | ~trial[WIDTH];
        rem_d   = fits ? trial[WIDTH-1:0] : rem_sh;
        quo_d   = {quo_q[WIDTH-2:0], fits};
    end

    // Control FSM, working registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            dbz_q       <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            quo_q   <= dividend;
                            rem_q   <= '0;
                            div_q   <= divisor;
                            cnt_q   <= '0;
                        end
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        quotient_q  <= quo_d;
                        remainder_q <= rem_d;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_32bit.sv
// tb_seq_div_32bit: directed self-checking bench for seq_div_32bit.
module tb_seq_div_32bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    seq_div_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start through one rising edge, then scrambles operands.
    task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // 32 RUN cycles: busy must be high and done low at each sample.
    // A spurious start with 50/5 is injected at step inject_k (negative = none).
    task automatic run_body(input string tag, input int inject_k);
        int bad;
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (k == inject_k) begin
                start    = 1'b1;
                dividend = 32'd50;
                divisor  = 32'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk({tag, "_run_cycles_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic check_done(input string tag, input logic [31:0] eq,
                              input logic [31:0] er, input logic edbz);
        @(negedge clk);
        chk({tag, "_done"},  32'(done), 32'd1);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_quot"},  quotient,  eq);
        chk({tag, "_rem"},   remainder, er);
        chk({tag, "_dbz"},   32'(div_by_zero), 32'(edbz));
    endtask

    task automatic check_idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"},      32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem",  remainder, 32'd0);
        chk("rst_dbz",  32'(div_by_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7 = 14 r 2, done after the 33rd edge counting the sampling edge
        drive_start(32'd100, 32'd7);
        run_body("d100_7", -1);
        check_done("d100_7", 32'd14, 32'd2, 1'b0);
        check_idle_after("d100_7");

        drive_start(32'hFFFF_FFFF, 32'd1);
        run_body("dmax_1", -1);
        check_done("dmax_1", 32'hFFFF_FFFF, 32'd0, 1'b0);
        check_idle_after("dmax_1");

        drive_start(32'd5, 32'd9);
        run_body("d5_9", -1);
        check_done("d5_9", 32'd0, 32'd5, 1'b0);

        // Large divisors exercise the bit shifted out of the partial remainder
        @(negedge clk);
        drive_start(32'hFFFF_FFFE, 32'hFFFF_FFFF);
        run_body("dbig1", -1);
        check_done("dbig1", 32'd0, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);
        drive_start(32'hFFFF_FFFF, 32'h8000_0001);
        run_body("dbig2", -1);
        check_done("dbig2", 32'd1, 32'h7FFF_FFFE, 1'b0);
        check_idle_after("dbig2");

        // Divide by zero: done right after the sampling edge
        drive_start(32'h1234_5678, 32'd0);
        check_done("dz", 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        check_idle_after("dz");

        // start during RUN is ignored
        drive_start(32'd100, 32'd7);
        run_body("ign", 10);
        check_done("ign", 32'd14, 32'd2, 1'b0);
        check_idle_after("ign");

        // Back-to-back: new start in the DONE cycle, no busy gap
        drive_start(32'd100, 32'd7);
        run_body("b2b_a", -1);
        check_done("b2b_a", 32'd14, 32'd2, 1'b0);
        drive_start(32'd81, 32'd9);
        run_body("b2b_b", -1);
        check_done("b2b_b", 32'd9, 32'd0, 1'b0);
        check_idle_after("b2b_b");

        // Asynchronous reset mid-run
        drive_start(32'd100, 32'd7);
        repeat (16) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_quot", quotient, 32'd0);
        chk("arst_rem",  remainder, 32'd0);
        chk("arst_dbz",  32'(div_by_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("arst_no_done", 32'(seen), 32'd0);

        drive_start(32'h8000_0000, 32'h0000_0010);
        run_body("d8_16", -1);
        check_done("d8_16", 32'h0800_0000, 32'd0, 1'b0);
        check_idle_after("d8_16");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
